montgomery_inverse: RTL and testbench

//   Modular inverse for the Kyber field: result = a^(N-2) mod N (Fermat), a^-1 for a != 0 mod N.

---
 rtl/mont_pkg.sv | 26 ++
 rtl/montgomery_reduce.sv | 49 ++++
 rtl/montgomery_inverse.sv | 202 ++++++++++++++++++++
 tb/tb_montgomery_inverse.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared constants and FSM state type for the Kyber-field Montgomery blocks.
//   N          prime modulus
//   R_LOG2     log2 of the Montgomery radix
//   N_PRIME    -N^-1 mod 2^R_LOG2
//   R_SQ_MODN  R^2 mod N, multiplies an operand into the Montgomery domain
//   R_MODN     R mod N, Montgomery form of 1
//   EXP        Fermat exponent N-2
package mont_pkg;

   localparam int unsigned N         = 3329;
   localparam int unsigned R_LOG2    = 12;
   localparam int unsigned N_PRIME   = 3327;
   localparam int unsigned R_SQ_MODN = 2385;
   localparam int unsigned R_MODN    = 767;
   localparam logic [11:0] EXP       = 12'(N - 2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TO_MONT,
      ST_SQR,
      ST_MUL,
      ST_FROM_MONT,
      ST_DONE
   } mont_state_e;

endpackage

// File: rtl/montgomery_reduce.sv
// Montgomery reduction y = x * 2^-12 mod N, result in [0, 2N).
// Valid for x < N * 2^12. One-cycle latency: valid_o follows en_i by one clock.
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   en_i     start a reduction of x_i
//   x_i      26-bit input (callers supply zero-extended 24-bit products)
//   valid_o  y_o holds the reduction of the x_i sampled with en_i
//   y_o      13-bit result, < 2N
module montgomery_reduce
   import mont_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_i,
   input  logic [25:0] x_i,
   output logic        valid_o,
   output logic [12:0] y_o
);

   logic [23:0] m_full;
   logic [11:0] m;
   logic [23:0] m_n;
   logic [25:0] sum;
   logic        unused_bits;
   logic        valid_q;
   logic [12:0] y_q;

   // The low 12 bits of x + m*N are zero by construction of m.
   assign m_full      = 24'(x_i[11:0]) * 24'(N_PRIME);
   assign m           = m_full[11:0];
   assign m_n         = 24'(m) * 24'(N);
   assign sum         = x_i + {2'b00, m_n};
   assign unused_bits = ^{sum[25], sum[11:0], m_full[23:12]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         y_q     <= '0;
      end else begin
         valid_q <= en_i;
         if (en_i) y_q <= sum[24:12];
      end
   end

   assign valid_o = valid_q;
   assign y_o     = y_q;

endmodule

// File: rtl/montgomery_inverse.sv
// Modular inverse in the Kyber field: result = a^(N-2) mod N, computed by
// left-to-right square-and-multiply in the Montgomery domain on one shared
// montgomery_reduce instance.
// Optional feature macro: MONT_INV_ZERO_ERR_EN adds the err output, flagging a
// captured operand that is 0 mod N.
// Ports:
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   start   one-cycle request, accepted only in IDLE
//   a       12-bit operand, captured with an accepted start
//   busy    high from the cycle after acceptance until done
//   result  canonical inverse 0..N-1, held until overwritten
//   done    one-cycle completion pulse
//   err     (MONT_INV_ZERO_ERR_EN only) operand was 0 mod N, valid with done
//
// state        | meaning
// ST_IDLE      | waiting for start
// ST_TO_MONT   | aM = reduce(a * R^2 mod N); acc = aM
// ST_SQR       | acc = reduce(acc * acc)
// ST_MUL       | acc = reduce(acc * aM), only for exponent bits that are 1
// ST_FROM_MONT | result = reduce(acc), leaves the Montgomery domain
// ST_DONE      | raise done next cycle, drop busy
module montgomery_inverse
   import mont_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [11:0] a,
   output logic        busy,
   output logic [11:0] result,
`ifdef MONT_INV_ZERO_ERR_EN
   output logic        err,
`endif
   output logic        done
);

   mont_state_e state_q, state_d;
   logic [11:0] a_q, a_d;
   logic [11:0] am_q, am_d;
   logic [11:0] acc_q, acc_d;
   logic [3:0]  idx_q, idx_d;
   logic        wait_q, wait_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [11:0] result_q, result_d;
   logic        zero_q, zero_d;
   logic        err_q, err_d;

   logic [11:0] op_a, op_b;
   logic [23:0] prod;
   logic        reduce_en;
   logic        red_valid;
   logic [12:0] red_y;
   logic [11:0] red_canon;
   logic        op_done;

   assign prod = {12'b0, op_a} * {12'b0, op_b};

   montgomery_reduce u_reduce (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (reduce_en),
      .x_i     ({2'b00, prod}),
      .valid_o (red_valid),
      .y_o     (red_y)
   );

   // Reduce output is < 2N, one subtract makes it canonical.
   assign red_canon = (red_y >= 13'(N)) ? 12'(red_y - 13'(N)) : red_y[11:0];

   // A valid seen before this op issued its en (e.g. left over after reset) is ignored.
   assign op_done = wait_q & red_valid;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      am_d      = am_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      wait_d    = wait_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      result_d  = result_q;
      zero_d    = zero_q;
      err_d     = err_q;
      op_a      = acc_q;
      op_b      = acc_q;
      reduce_en = 1'b0;

      if (state_q inside {ST_TO_MONT, ST_SQR, ST_MUL, ST_FROM_MONT}) begin
         if (!wait_q) begin
            reduce_en = 1'b1;
            wait_d    = 1'b1;
         end else if (red_valid) begin
            wait_d = 1'b0;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = a;
               zero_d  = (a == 12'd0) || (a == 12'(N));
               err_d   = 1'b0;
               wait_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_TO_MONT;
            end
         end
         ST_TO_MONT: begin
            op_a = a_q;
            op_b = 12'(R_SQ_MODN);
            if (op_done) begin
               am_d    = red_canon;
               acc_d   = red_canon;
               idx_d   = 4'd10;
               state_d = ST_SQR;
            end
         end
         ST_SQR: begin
            if (op_done) begin
               acc_d = red_canon;
               if (EXP[idx_q])         state_d = ST_MUL;
               else if (idx_q == 4'd0) state_d = ST_FROM_MONT;
               else begin
                  idx_d   = idx_q - 4'd1;
                  state_d = ST_SQR;
               end
            end
         end
         ST_MUL: begin
            op_b = am_q;
            if (op_done) begin
               acc_d = red_canon;
               if (idx_q == 4'd0) state_d = ST_FROM_MONT;
               else begin
                  idx_d   = idx_q - 4'd1;
                  state_d = ST_SQR;
               end
            end
         end
         ST_FROM_MONT: begin
            op_b = 12'd1;
            if (op_done) begin
`ifdef MONT_INV_ZERO_ERR_EN
               result_d = zero_q ? 12'd0 : red_canon;
`else
               result_d = red_canon;
`endif
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            err_d   = zero_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         am_q     <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         wait_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         am_q     <= am_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         wait_q   <= wait_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
`ifdef MONT_INV_ZERO_ERR_EN
   assign err    = err_q;
`else
   logic unused_err;
   assign unused_err = err_q ^ err_d;
`endif

endmodule

// File: tb/tb_montgomery_inverse.sv
// Scoreboard bench for montgomery_inverse: stimulus pushes expected results,
// an independent monitor pops and checks them on every done pulse.
module tb_montgomery_inverse;

   localparam int NMOD   = 3329;
   localparam int NRED   = 22;
   localparam int LAT    = 2 + NRED * (1 + 1);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] a = '0;
   logic        busy, done;
   logic [11:0] result;
`ifdef MONT_INV_ZERO_ERR_EN
   logic        err;
`endif

   montgomery_inverse dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .busy   (busy),
      .result (result),
`ifdef MONT_INV_ZERO_ERR_EN
      .err    (err),
`endif
      .done   (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int av;
      int exp_res;
      bit exp_err;
      int t_issue;
      int en_snap;
   } txn_t;

   txn_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   en_total = 0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_n && dut.reduce_en) en_total = en_total + 1;
   end

   // Fermat inverse by repeated multiplication, independent of Montgomery form.
   function automatic int ref_inv(input int av);
      int x, r;
      x = av % NMOD;
      r = 1;
      if (x == 0) return 0;
      for (int k = 0; k < NMOD - 2; k++) r = (r * x) % NMOD;
      return r;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got result %0d with no request pending", result);
         end else begin
            txn_t t;
            t = q.pop_front();
            check($sformatf("result a=%0d", t.av), int'(result), t.exp_res);
            check($sformatf("latency a=%0d", t.av), cyc - t.t_issue, LAT);
            check($sformatf("reduce_en a=%0d", t.av), en_total - t.en_snap, NRED);
            check("busy_low_at_done", int'(busy), 0);
            if (t.av % NMOD != 0)
               check($sformatf("a*inv a=%0d", t.av), (t.av * int'(result)) % NMOD, 1);
`ifdef MONT_INV_ZERO_ERR_EN
            check($sformatf("err a=%0d", t.av), int'(err), int'(t.exp_err));
`endif
         end
      end
   end

   task automatic issue(input int v, input int exp_res);
      txn_t t;
      @(negedge clk);
      t.av      = v;
      t.exp_res = exp_res;
      t.exp_err = ((v % NMOD) == 0);
      t.t_issue = cyc;
      t.en_snap = en_total;
      q.push_back(t);
      start = 1'b1;
      a     = 12'(v);
      @(negedge clk);
      start = 1'b0;
      a     = 12'($urandom);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 4 * LAT && q.size() != 0; k++) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d requests still pending", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   typedef struct {
      int av;
      int res;
   } vec_t;

   vec_t dir[$];

   initial begin
      dir = '{'{1, 1}, '{2, 1665}, '{17, 1175}, '{3328, 3328},
              '{3334, 666}, '{0, 0}, '{3329, 0}};

      repeat (3) @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_result", int'(result), 0);
`ifdef MONT_INV_ZERO_ERR_EN
      check("reset_err", int'(err), 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      foreach (dir[i]) begin
         issue(dir[i].av, dir[i].res);
         wait_idle();
      end

      // Starts while busy must be ignored.
      issue(2, 1665);
      for (int k = 0; k < 6; k++) begin
         repeat (5) @(negedge clk);
         start = 1'b1;
         a     = 12'd17;
         @(negedge clk);
         start = 1'b0;
      end
      wait_idle();
      repeat (LAT + 10) @(negedge clk);
      issue(17, 1175);
      wait_idle();

      // Abort mid-operation.
      issue(5, 666);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_result", int'(result), 0);
      q.delete();
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(1, 1);
      wait_idle();

      for (int k = 0; k < 150; k++) begin
         int v;
         v = int'($urandom_range(0, 4095));
         issue(v, ref_inv(v));
         wait_idle();
      end

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
